// File: rtl/avalon_irq_pio_pkg.sv
// Shared constants for the Avalon-MM PIO: bus widths, register word addresses
// and counter sizing helper.
package avalon_irq_pio_pkg;

    localparam int unsigned AVS_ADDR_W = 3;
    localparam int unsigned AVS_DATA_W = 32;

    localparam logic [AVS_ADDR_W-1:0] ADDR_DATA_IN  = 3'd0;
    localparam logic [AVS_ADDR_W-1:0] ADDR_DATA_OUT = 3'd1;
    localparam logic [AVS_ADDR_W-1:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [AVS_ADDR_W-1:0] ADDR_EDGE_CAP = 3'd3;
    localparam logic [AVS_ADDR_W-1:0] ADDR_RISE_EN  = 3'd4;
    localparam logic [AVS_ADDR_W-1:0] ADDR_FALL_EN  = 3'd5;
    localparam logic [AVS_ADDR_W-1:0] ADDR_OUT_SET  = 3'd6;
    localparam logic [AVS_ADDR_W-1:0] ADDR_OUT_CLR  = 3'd7;

    // Bits needed to count 0..n inclusive, never less than one.
    function automatic int unsigned cnt_width(input int n);
        if ($clog2(n + 1) < 1) return 1;
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/avalon_irq_pio_if.sv
// Avalon-MM slave port bundle for the PIO register file.
interface avalon_irq_pio_if
    import avalon_irq_pio_pkg::*;
;
    logic [AVS_ADDR_W-1:0] avs_address;
    logic                  avs_read;
    logic                  avs_write;
    logic [AVS_DATA_W-1:0] avs_writedata;
    logic [AVS_DATA_W-1:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/pio_debounce.sv
// One input channel: metastability synchroniser followed by a stable-count
// debouncer; during warm-up the stable value simply tracks the synced value.
module pio_debounce
    import avalon_irq_pio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic warmup,
    input  logic din,
    output logic dout
);
    localparam int unsigned     CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES == 0) ? 0 : DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   synced;

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        synced   = sync_q[SYNC_STAGES-1];
        stable_d = stable_q;
        cnt_d    = '0;
        if (warmup || (DEBOUNCE_CYCLES == 0)) begin
            stable_d = synced;
        end else if (synced != stable_q) begin
            // Accept the new level only after it has held for the full window.
            if (cnt_q == CNT_LAST) stable_d = synced;
            else                   cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign dout = stable_q;

endmodule

// File: rtl/avalon_irq_pio.sv
// Avalon-MM parallel I/O with debounced inputs, edge capture and a maskable
// level interrupt; holds the register file, warm-up counter and read mux.
module avalon_irq_pio
    import avalon_irq_pio_pkg::*;
#(
    parameter int unsigned      WIDTH           = 10,
    parameter int unsigned      SYNC_STAGES     = 2,
    parameter int unsigned      DEBOUNCE_CYCLES = 500000,
    parameter logic [WIDTH-1:0] OUT_RESET       = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    avalon_irq_pio_if.slave   avs,
    input  logic [WIDTH-1:0]  pio_in,
    output logic [WIDTH-1:0]  pio_out,
    output logic              irq
);
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int unsigned WARM_W      = cnt_width(WARM_CYCLES);

    logic [WARM_W-1:0]     warm_cnt_q, warm_cnt_d;
    logic                  warmup;
    logic [WIDTH-1:0]      data_in, prev_q, prev_d, new_edges;
    logic [WIDTH-1:0]      out_q, out_d, mask_q, mask_d, cap_q, cap_d;
    logic [WIDTH-1:0]      rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0]      wdata;
    logic [AVS_DATA_W-1:0] readdata_q, readdata_d, rd_mux;
    logic                  unused_wdata;

    assign wdata        = avs.avs_writedata[WIDTH-1:0];
    assign unused_wdata = ^avs.avs_writedata;

    // Saturating warm-up counter; edge detection stays off until it completes.
    assign warmup     = (warm_cnt_q != WARM_W'(WARM_CYCLES));
    assign warm_cnt_d = warmup ? warm_cnt_q + WARM_W'(1) : warm_cnt_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        pio_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .warmup  (warmup),
            .din     (pio_in[i]),
            .dout    (data_in[i])
        );
    end

    always_comb begin
        prev_d    = data_in;
        new_edges = '0;
        if (!warmup) begin
            new_edges = (data_in & ~prev_q & rise_q) | (~data_in & prev_q & fall_q);
        end
        out_d  = out_q;
        mask_d = mask_q;
        rise_d = rise_q;
        fall_d = fall_q;
        cap_d  = cap_q | new_edges;
        if (avs.avs_write) begin
            case (avs.avs_address)
                ADDR_DATA_OUT: out_d  = wdata;
                ADDR_IRQ_MASK: mask_d = wdata;
                // A fresh edge on the same bit overrides the clear.
                ADDR_EDGE_CAP: cap_d  = (cap_q & ~wdata) | new_edges;
                ADDR_RISE_EN:  rise_d = wdata;
                ADDR_FALL_EN:  fall_d = wdata;
                ADDR_OUT_SET:  out_d  = out_q | wdata;
                ADDR_OUT_CLR:  out_d  = out_q & ~wdata;
                default:       ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_DATA_IN:  rd_mux = AVS_DATA_W'(data_in);
            ADDR_DATA_OUT: rd_mux = AVS_DATA_W'(out_q);
            ADDR_IRQ_MASK: rd_mux = AVS_DATA_W'(mask_q);
            ADDR_EDGE_CAP: rd_mux = AVS_DATA_W'(cap_q);
            ADDR_RISE_EN:  rd_mux = AVS_DATA_W'(rise_q);
            ADDR_FALL_EN:  rd_mux = AVS_DATA_W'(fall_q);
            default:       rd_mux = '0;
        endcase
        readdata_d = avs.avs_read ? rd_mux : readdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warm_cnt_q <= '0;
            prev_q     <= '0;
            out_q      <= OUT_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            rise_q     <= '1;
            fall_q     <= '0;
            readdata_q <= '0;
        end else begin
            warm_cnt_q <= warm_cnt_d;
            prev_q     <= prev_d;
            out_q      <= out_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            readdata_q <= readdata_d;
        end
    end

    assign pio_out          = out_q;
    assign irq              = |(cap_q & mask_q);
    assign avs.avs_readdata = readdata_q;

endmodule
